instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have the port `Clk`, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 The block SHALL have the port `Rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port `Step`, input, 1 bit: single-step button, already synchronised; only a rising edge starts an instruction.
REQ-004 The block SHALL have the port `Run`, input, 1 bit: free-run mode; while high, instructions start back-to-back without `Step`.
REQ-005 The block SHALL have the decode-flag input ports `Halt`, `Jump`, `Branch`, `BranchTaken`, `IsLoad`, `IsStore`, 1 bit each, valid from DECODE onward.
REQ-006 The block SHALL have the port `MemReady`, input, 1 bit: data memory has completed the current access.
REQ-007 The block SHALL have the port `PcEnable`, output, 1 bit: one-cycle load strobe to the program counter.
REQ-008 The block SHALL have the port `PcSel`, output, 1 bit: 0 selects PC+4 and 1 selects the jump/branch target; it is meaningful only while `PcEnable`=1 and is 0 otherwise.
REQ-009 The block SHALL have the port `IrLoad`, output, 1 bit: instruction register load strobe.
REQ-010 The block SHALL have the ports `MemRead` and `MemWrite`, output, 1 bit each: data memory controls.
REQ-011 The block SHALL have the port `RegWrite`, output, 1 bit: register file write strobe.
REQ-012 The block SHALL have the ports `Busy` and `Halted`, output, 1 bit each: status flags.
REQ-013 The block SHALL have the port `State`, output, 3 bits: current state encoding, provided for debug LEDs.
REQ-014 The block SHALL have the port `InstrCount`, output, 32 bits: count of retired instructions.

Function
REQ-015 The state encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; the value 7 SHALL go to IDLE on the next clock.
REQ-016 A register `Step_d` SHALL capture `Step` every cycle; a step edge SHALL be defined as `Step` & ~`Step_d`.
REQ-017 In IDLE, on a step edge or `Run`=1, the block SHALL go to FETCH; otherwise it SHALL remain in IDLE.
REQ-018 In FETCH, the block SHALL assert `IrLoad`=1 and go to DECODE unconditionally.
REQ-019 In DECODE, the block SHALL go to HALT if `Halt`=1; otherwise it SHALL go to EXEC.
REQ-020 In EXEC, priority SHALL be as follows: if (`IsLoad` | `IsStore`), go to MEM; else if `Jump` | (`Branch` & `BranchTaken`), assert `PcEnable`=1 and `PcSel`=1, retire, and go to IDLE; else if `Branch` (not taken), assert `PcEnable`=1 and `PcSel`=0, retire, and go to IDLE; else go to WB.
REQ-021 In MEM, the block SHALL hold `MemRead`=`IsLoad` and `MemWrite`=`IsStore` for every cycle spent in MEM, and SHALL wait without limit until `MemReady`=1.
REQ-022 In MEM with `MemReady`=1, a load SHALL go to WB; a store SHALL assert `PcEnable`=1 and `PcSel`=0, retire, and go to IDLE.
REQ-023 In WB, the block SHALL assert `RegWrite`=1 and `PcEnable`=1 with `PcSel`=0, retire, and go to IDLE.
REQ-024 In HALT, the block SHALL assert `Halted`=1, keep all strobes at 0, and remain in HALT until `Rst`.
REQ-025 `Busy` SHALL be 1 in FETCH, DECODE, EXEC, MEM and WB, and 0 in IDLE and HALT.
REQ-026 All strobe outputs SHALL be combinational from state and inputs; `PcEnable` SHALL be high for exactly one cycle per retired instruction and never at any other time.
REQ-027 Retiring an instruction SHALL increment `InstrCount` by 1 on the same clock edge that leaves the retiring state; the count SHALL wrap from 32'hFFFFFFFF to 32'h00000000.
REQ-028 Step edges arriving while `Busy`=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 If `Run` falls mid-instruction, the current instruction SHALL complete and the block SHALL then stay in IDLE.
REQ-030 A halt instruction SHALL NOT retire, SHALL NOT assert `PcEnable`, and SHALL NOT increment `InstrCount`.
REQ-031 Latency SHALL be as follows: for an ALU instruction, a step edge sampled at clock edge N SHALL give FETCH at N+1 and the `PcEnable` cycle in WB at N+4; jump/branch SHALL take 3 cycles after the edge; a load with zero wait SHALL take 5; a store SHALL take 4 plus any MEM wait cycles.

Reset
REQ-032 When `Rst`=1 at a clock edge, the block SHALL set State=IDLE and `InstrCount`=0, and SHALL set `Step_d`=1 so that a button held through reset produces no edge.
REQ-033 In the cycle following reset, all outputs SHALL be 0.
REQ-034 Reset SHALL override any state, including MEM mid-wait and HALT; an in-flight instruction SHALL be abandoned without `PcEnable`.

Verification
REQ-035 ALU step: pulse `Step` 0→1 with no flags → `State` SHALL go 1,2,3,5,0; `PcEnable`=1 and `RegWrite`=1 SHALL occur together only in the WB cycle; `InstrCount` SHALL equal 1.
REQ-036 Taken branch: `Branch`=1, `BranchTaken`=1 → `PcEnable`=1 with `PcSel`=1 SHALL occur in the EXEC cycle, with no `RegWrite` and no WB; a not-taken branch SHALL give `PcSel`=0 in EXEC.
REQ-037 Load with `MemReady` low for 3 cycles → `MemRead`=1 SHALL hold for 4 MEM cycles, then WB SHALL follow with `RegWrite`=1; `InstrCount` SHALL increment exactly once.
REQ-038 `Run`=1 for 3 ALU instructions, then `Run`=0 during the DECODE of the 3rd → exactly 3 `PcEnable` pulses, final `State`=0, `InstrCount`=3; a second `Step` edge issued during EXEC SHALL be ignored.
REQ-039 `Halt`=1 at DECODE → `State`=6 and `Halted`=1 SHALL persist through 20 step edges and `Run`=1, with `InstrCount` unchanged; `Rst` SHALL then restore IDLE with `InstrCount`=0.
REQ-040 Preload `InstrCount` to 32'hFFFFFFFF via forced state, then retire one instruction → `InstrCount` SHALL read 0; `Rst` asserted mid-MEM SHALL give `State`=0 with no `PcEnable` pulse.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB for a simple core,
// driven by a single-step button or free-run mode, and counts retired instructions.
module instr_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Step,
  input  logic        Run,
  input  logic        Halt,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        BranchTaken,
  input  logic        IsLoad,
  input  logic        IsStore,
  input  logic        MemReady,
  output logic        PcEnable,
  output logic        PcSel,
  output logic        IrLoad,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        Busy,
  output logic        Halted,
  output logic [2:0]  State,
  output logic [31:0] InstrCount
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        step_q;
  logic        step_edge;
  logic        retire;
  logic [31:0] instr_count_q;

  // Only consulted in IDLE, so edges seen while busy are dropped rather than queued.
  assign step_edge = Step & ~step_q;

  always_comb begin
    state_d  = state_q;
    PcEnable = 1'b0;
    PcSel    = 1'b0;
    IrLoad   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    retire   = 1'b0;
    case (state_q)
      StIdle: begin
        if (step_edge || Run) state_d = StFetch;
      end
      StFetch: begin
        IrLoad  = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = Halt ? StHalt : StExec;
      end
      StExec: begin
        if (IsLoad || IsStore) begin
          state_d = StMem;
        end else if (Jump || (Branch && BranchTaken)) begin
          PcEnable = 1'b1;
          PcSel    = 1'b1;
          retire   = 1'b1;
          state_d  = StIdle;
        end else if (Branch) begin
          PcEnable = 1'b1;
          retire   = 1'b1;
          state_d  = StIdle;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        MemRead  = IsLoad;
        MemWrite = IsStore;
        if (MemReady) begin
          if (IsLoad) begin
            state_d = StWb;
          end else begin
            PcEnable = 1'b1;
            retire   = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StWb: begin
        RegWrite = 1'b1;
        PcEnable = 1'b1;
        retire   = 1'b1;
        state_d  = StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign Busy       = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec) ||
                      (state_q == StMem) || (state_q == StWb);
  assign Halted     = (state_q == StHalt);
  assign State      = state_q;
  assign InstrCount = instr_count_q;

  // step_q resets high so a button held through reset does not look like a fresh press.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= StIdle;
      step_q        <= 1'b1;
      instr_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      step_q  <= Step;
      if (retire) instr_count_q <= instr_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-computed state/strobe sequences per instruction type.
module tb_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Rst, Step, Run, Halt, Jump, Branch, BranchTaken, IsLoad, IsStore, MemReady;
  logic        PcEnable, PcSel, IrLoad, MemRead, MemWrite, RegWrite, Busy, Halted;
  logic [2:0]  State;
  logic [31:0] InstrCount;
  logic [7:0]  outs;

  int compared   = 0;
  int mismatched = 0;
  int pulses;

  instr_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Step(Step), .Run(Run), .Halt(Halt), .Jump(Jump),
    .Branch(Branch), .BranchTaken(BranchTaken), .IsLoad(IsLoad), .IsStore(IsStore),
    .MemReady(MemReady), .PcEnable(PcEnable), .PcSel(PcSel), .IrLoad(IrLoad),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .Busy(Busy),
    .Halted(Halted), .State(State), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  // Bit order: PcEnable PcSel IrLoad MemRead MemWrite RegWrite Busy Halted
  assign outs = {PcEnable, PcSel, IrLoad, MemRead, MemWrite, RegWrite, Busy, Halted};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] run_exp [17];
    run_exp = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0,
                3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0};
    {Step, Run, Halt, Jump, Branch, BranchTaken, IsLoad, IsStore, MemReady} = '0;
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    #1;
    chk("reset_state", State, 0);
    chk("reset_outs", outs, 0);
    chk("reset_count", InstrCount, 0);
    tick();

    // ALU instruction: 1,2,3,5,0
    Step = 1'b1;
    tick();
    chk("alu_fetch_state", State, 1);
    chk("alu_fetch_outs", outs, 8'h22);
    Step = 1'b0;
    tick();
    chk("alu_decode_state", State, 2);
    chk("alu_decode_outs", outs, 8'h02);
    tick();
    chk("alu_exec_state", State, 3);
    chk("alu_exec_outs", outs, 8'h02);
    tick();
    chk("alu_wb_state", State, 5);
    chk("alu_wb_outs", outs, 8'h86);
    chk("alu_wb_count", InstrCount, 0);
    tick();
    chk("alu_idle_state", State, 0);
    chk("alu_idle_outs", outs, 0);
    chk("alu_count", InstrCount, 1);

    // Taken branch retires from EXEC with PcSel=1
    Step = 1'b1; Branch = 1'b1; BranchTaken = 1'b1;
    tick();
    chk("br_t_fetch", State, 1);
    Step = 1'b0;
    tick();
    chk("br_t_decode", State, 2);
    tick();
    chk("br_t_exec_state", State, 3);
    chk("br_t_exec_outs", outs, 8'hC2);
    tick();
    chk("br_t_idle", State, 0);
    chk("br_t_count", InstrCount, 2);

    // Not-taken branch: PcSel=0 in EXEC
    BranchTaken = 1'b0; Step = 1'b1;
    tick();
    Step = 1'b0;
    tick();
    tick();
    chk("br_nt_exec_state", State, 3);
    chk("br_nt_exec_outs", outs, 8'h82);
    tick();
    chk("br_nt_idle", State, 0);
    chk("br_nt_count", InstrCount, 3);
    Branch = 1'b0;

    // Load with three wait cycles
    IsLoad = 1'b1; MemReady = 1'b0; Step = 1'b1;
    tick();
    Step = 1'b0;
    tick();
    tick();
    chk("ld_exec_outs", outs, 8'h02);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_wait_state", State, 4);
      chk("ld_mem_wait_outs", outs, 8'h12);
      tick();
    end
    MemReady = 1'b1;
    #1;
    chk("ld_mem_last_state", State, 4);
    chk("ld_mem_last_outs", outs, 8'h12);
    tick();
    chk("ld_wb_state", State, 5);
    chk("ld_wb_outs", outs, 8'h86);
    chk("ld_wb_count", InstrCount, 3);
    MemReady = 1'b0; IsLoad = 1'b0;
    tick();
    chk("ld_idle", State, 0);
    chk("ld_count", InstrCount, 4);

    // Store with zero wait retires from MEM
    IsStore = 1'b1; MemReady = 1'b1; Step = 1'b1;
    tick();
    Step = 1'b0;
    tick();
    tick();
    chk("st_exec_outs", outs, 8'h02);
    tick();
    chk("st_mem_state", State, 4);
    chk("st_mem_outs", outs, 8'h8A);
    tick();
    chk("st_idle", State, 0);
    chk("st_count", InstrCount, 5);
    IsStore = 1'b0; MemReady = 1'b0;

    // Free-run three ALU instructions, stray step during EXEC of the third
    Run = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (PcEnable) pulses++;
      chk("run_state", {29'd0, State}, {29'd0, run_exp[k-1]});
      if (k == 12) Run = 1'b0;
      if (k == 13) Step = 1'b1;
      if (k == 14) Step = 1'b0;
    end
    chk("run_pulses", pulses, 3);
    chk("run_count", InstrCount, 8);

    // Halt: sticky against steps and Run, no retire
    Halt = 1'b1; Step = 1'b1;
    tick();
    Step = 1'b0;
    tick();
    tick();
    chk("halt_state", State, 6);
    chk("halt_outs", outs, 8'h01);
    Run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Step = 1'b1;
      tick();
      Step = 1'b0;
      tick();
      chk("halt_hold_state", State, 6);
      chk("halt_hold_outs", outs, 8'h01);
    end
    chk("halt_count", InstrCount, 8);
    Rst = 1'b1;
    tick();
    Rst = 1'b0; Halt = 1'b0; Run = 1'b0;
    #1;
    chk("halt_rst_state", State, 0);
    chk("halt_rst_count", InstrCount, 0);
    chk("halt_rst_outs", outs, 0);
    tick();

    // Counter wrap from all-ones
    force dut.instr_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.instr_count_q;
    #1;
    chk("wrap_preload", InstrCount, 32'hFFFF_FFFF);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    tick();
    tick();
    tick();
    chk("wrap_wb_outs", outs, 8'h86);
    tick();
    chk("wrap_state", State, 0);
    chk("wrap_count", InstrCount, 0);

    // Reset while waiting in MEM abandons the load
    IsLoad = 1'b1; MemReady = 1'b0; Step = 1'b1;
    tick();
    Step = 1'b0;
    tick();
    tick();
    tick();
    chk("rmem_state", State, 4);
    tick();
    chk("rmem_state2", State, 4);
    Rst = 1'b1;
    #1;
    chk("rmem_outs", outs, 8'h12);
    tick();
    Rst = 1'b0;
    #1;
    chk("rmem_rst_state", State, 0);
    chk("rmem_rst_outs", outs, 0);
    chk("rmem_rst_count", InstrCount, 0);
    IsLoad = 1'b0;
    tick();
    tick();
    chk("rmem_after_state", State, 0);
    chk("rmem_after_count", InstrCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
